// File: rtl/hdc_pkg.sv
// Shared definitions for the chunked HDC spam/ham classifier: datapath op codes,
// verdict codes and the byte-to-symbol mapping used by the tokenizer.
package hdc_pkg;
    localparam int NUM_CHAR = 37;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ACC = 2'd1,
        OP_SUM = 2'd2,
        OP_CMP = 2'd3
    } dp_op_e;

    localparam logic [1:0] RES_SPAM  = 2'b00;
    localparam logic [1:0] RES_HAM   = 2'b01;
    localparam logic [1:0] RES_UNDEC = 2'b11;

    // Letters fold case onto 11..36, digits onto 1..10, everything else is symbol 0.
    function automatic logic [5:0] to_symbol(input logic [7:0] ch);
        logic [5:0] sym;
        sym = 6'd0;
        if (ch >= 8'h41 && ch <= 8'h5a) begin
            sym = 6'(ch - 8'h41) + 6'd11;
        end else if (ch >= 8'h61 && ch <= 8'h7a) begin
            sym = 6'(ch - 8'h61) + 6'd11;
        end else if (ch >= 8'h30 && ch <= 8'h39) begin
            sym = 6'(ch - 8'h30) + 6'd1;
        end
        return sym;
    endfunction
endpackage

// File: rtl/hdc_token_buf.sv
// Token store: written by the tokenizer while a message loads, read back by the
// encode-phase token counter.
module hdc_token_buf #(
    parameter int DEPTH = 200,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [5:0]    rd_data
);
    logic [5:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/hdc_classify_ctrl.sv
// Sequencer for the chunked HDC classifier: tokenizes the byte stream, then drives
// ACC/SUM/CMP ops chunk by chunk and turns the Hamming distance totals into a verdict.
module hdc_classify_ctrl
    import hdc_pkg::*;
#(
    parameter int MAX_LENGTH = 200,
    parameter int DIM        = 10000,
    parameter int CHUNK      = 100,
    parameter int DP_LAT     = 2,
    localparam int NCHK      = DIM / CHUNK,
    localparam int CW        = $clog2(NCHK),
    localparam int SUM_W     = $clog2(MAX_LENGTH * DIM) + 2,
    localparam int CNT_W     = $clog2(DIM + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic [7:0]              char_data,
    input  logic                    char_last,
    output logic [1:0]              dp_op,
    output logic                    dp_acc_clr,
    output logic [CW-1:0]           dp_chunk,
    output logic [5:0]              dp_sym,
    output logic signed [SUM_W-1:0] thr_sum,
    input  logic                    dp_rsp_valid,
    input  logic signed [SUM_W-1:0] dp_rsp_sum,
    input  logic [CNT_W-1:0]        dp_rsp_dham,
    input  logic [CNT_W-1:0]        dp_rsp_dspam,
    output logic                    busy,
    output logic                    result_valid,
    output logic [1:0]              result
);
    localparam int LEN_W = $clog2(MAX_LENGTH + 1);
    localparam int AW    = $clog2(MAX_LENGTH);
    localparam int RW    = $clog2(NCHK + 1);

    if (DIM % CHUNK != 0 || NCHK < 2) begin : g_bad_chunking
        $error("DIM must be a multiple of CHUNK giving at least two chunks");
    end
    if (DP_LAT < 1 || NUM_CHAR > 64) begin : g_bad_cfg
        $error("DP_LAT must be at least 1 and symbol ids must fit in 6 bits");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_ENC, ST_SUM, ST_SDRN, ST_CMP, ST_CDRN, ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d, tok_q, tok_d;
    logic [CW-1:0]           chunk_q, chunk_d;
    logic [RW-1:0]           rsp_cnt_q, rsp_cnt_d;
    logic signed [SUM_W-1:0] total_q, total_d, thr_q, thr_d;
    logic [CNT_W-1:0]        cnt_ham_q, cnt_ham_d, cnt_spam_q, cnt_spam_d;
    logic [1:0]              result_q, result_d;

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [5:0]              sym_rd;
    logic                    chunk_last, tok_last;

    hdc_token_buf #(.DEPTH(MAX_LENGTH), .AW(AW)) u_token_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (to_symbol(char_data)),
        .rd_addr (AW'(tok_q)),
        .rd_data (sym_rd)
    );

    assign chunk_last = (chunk_q == CW'(NCHK - 1));
    assign tok_last   = (tok_q == len_q - LEN_W'(1));
    assign dp_chunk   = chunk_q;
    assign dp_sym     = sym_rd;
    assign thr_sum    = thr_q;
    assign result     = result_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        tok_d        = tok_q;
        chunk_d      = chunk_q;
        rsp_cnt_d    = rsp_cnt_q;
        total_d      = total_q;
        thr_d        = thr_q;
        cnt_ham_d    = cnt_ham_q;
        cnt_spam_d   = cnt_spam_q;
        result_d     = result_q;
        wr_en        = 1'b0;
        wr_addr      = AW'(len_q);
        char_ready   = 1'b0;
        dp_op        = OP_NOP;
        dp_acc_clr   = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;

        // Responses are counted independently of issue, including one landing with the last issue.
        if (dp_rsp_valid) begin
            if (state_q == ST_SUM || state_q == ST_SDRN) begin
                total_d   = total_q + dp_rsp_sum;
                rsp_cnt_d = rsp_cnt_q + RW'(1);
            end else if (state_q == ST_CMP || state_q == ST_CDRN) begin
                cnt_ham_d  = cnt_ham_q + dp_rsp_dham;
                cnt_spam_d = cnt_spam_q + dp_rsp_dspam;
                rsp_cnt_d  = rsp_cnt_q + RW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                busy       = 1'b0;
                char_ready = 1'b1;
                if (char_valid) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    len_d      = LEN_W'(1);
                    tok_d      = '0;
                    chunk_d    = '0;
                    rsp_cnt_d  = '0;
                    total_d    = '0;
                    cnt_ham_d  = '0;
                    cnt_spam_d = '0;
                    state_d    = char_last ? ST_ENC : ST_LOAD;
                end
            end
            ST_LOAD: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    // Bytes past MAX_LENGTH are accepted but not stored.
                    if (len_q < LEN_W'(MAX_LENGTH)) begin
                        wr_en = 1'b1;
                        len_d = len_q + LEN_W'(1);
                    end
                    if (char_last) state_d = ST_ENC;
                end
            end
            ST_ENC: begin
                dp_op      = OP_ACC;
                dp_acc_clr = (tok_q == '0);
                if (tok_last) begin
                    tok_d = '0;
                    if (chunk_last) begin
                        chunk_d = '0;
                        state_d = ST_SUM;
                    end else begin
                        chunk_d = chunk_q + CW'(1);
                    end
                end else begin
                    tok_d = tok_q + LEN_W'(1);
                end
            end
            ST_SUM: begin
                dp_op = OP_SUM;
                if (chunk_last) begin
                    chunk_d = '0;
                    state_d = ST_SDRN;
                end else begin
                    chunk_d = chunk_q + CW'(1);
                end
            end
            ST_SDRN: begin
                if (rsp_cnt_q == RW'(NCHK)) begin
                    thr_d     = total_q;
                    rsp_cnt_d = '0;
                    state_d   = ST_CMP;
                end
            end
            ST_CMP: begin
                dp_op = OP_CMP;
                if (chunk_last) begin
                    chunk_d = '0;
                    state_d = ST_CDRN;
                end else begin
                    chunk_d = chunk_q + CW'(1);
                end
            end
            ST_CDRN: begin
                if (rsp_cnt_q == RW'(NCHK)) begin
                    if (cnt_ham_q > cnt_spam_q)      result_d = RES_SPAM;
                    else if (cnt_ham_q < cnt_spam_q) result_d = RES_HAM;
                    else                             result_d = RES_UNDEC;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b0;
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            tok_q      <= '0;
            chunk_q    <= '0;
            rsp_cnt_q  <= '0;
            total_q    <= '0;
            thr_q      <= '0;
            cnt_ham_q  <= '0;
            cnt_spam_q <= '0;
            result_q   <= RES_SPAM;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            tok_q      <= tok_d;
            chunk_q    <= chunk_d;
            rsp_cnt_q  <= rsp_cnt_d;
            total_q    <= total_d;
            thr_q      <= thr_d;
            cnt_ham_q  <= cnt_ham_d;
            cnt_spam_q <= cnt_spam_d;
            result_q   <= result_d;
        end
    end
endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Bench for hdc_classify_ctrl with a small behavioural datapath responder and a
// message-level reference model (token list, op counts, verdict, latency).
module tb_hdc_classify_ctrl;
    import hdc_pkg::*;

    localparam int MAX_LENGTH = 200;
    localparam int DIM        = 64;
    localparam int CHUNK      = 16;
    localparam int DP_LAT     = 2;
    localparam int NCHK       = DIM / CHUNK;
    localparam int CW         = $clog2(NCHK);
    localparam int SUM_W      = $clog2(MAX_LENGTH * DIM) + 2;
    localparam int CNT_W      = $clog2(DIM + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    char_valid, char_ready, char_last;
    logic [7:0]              char_data;
    logic [1:0]              dp_op;
    logic                    dp_acc_clr;
    logic [CW-1:0]           dp_chunk;
    logic [5:0]              dp_sym;
    logic signed [SUM_W-1:0] thr_sum;
    logic                    dp_rsp_valid;
    logic signed [SUM_W-1:0] dp_rsp_sum;
    logic [CNT_W-1:0]        dp_rsp_dham, dp_rsp_dspam;
    logic                    busy, result_valid;
    logic [1:0]              result;

    hdc_classify_ctrl #(.MAX_LENGTH(MAX_LENGTH), .DIM(DIM), .CHUNK(CHUNK), .DP_LAT(DP_LAT)) dut (
        .clk(clk), .reset(reset),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data), .char_last(char_last),
        .dp_op(dp_op), .dp_acc_clr(dp_acc_clr), .dp_chunk(dp_chunk), .dp_sym(dp_sym), .thr_sum(thr_sum),
        .dp_rsp_valid(dp_rsp_valid), .dp_rsp_sum(dp_rsp_sum),
        .dp_rsp_dham(dp_rsp_dham), .dp_rsp_dspam(dp_rsp_dspam),
        .busy(busy), .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int sym; int chunk; bit clr; } acc_t;

    acc_t                    acc_log[$];
    int                      n_sum, n_cmp, n_rv, rv_cyc, thr_bad;
    logic [1:0]              rv_res;
    logic signed [SUM_W-1:0] exp_thr_run;
    int                      sum_tab[NCHK], dham_tab[NCHK], dspam_tab[NCHK];
    bit                      pv[8];
    int                      ps[8], ph[8], pp[8];
    logic [7:0]              msg[$];
    int                      checks = 0, errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Datapath stand-in: answers each SUM/CMP DP_LAT cycles later from the tables; logs ACC ops.
    initial begin : responder
        int s, f;
        acc_t a;
        dp_rsp_valid = 1'b0; dp_rsp_sum = '0; dp_rsp_dham = '0; dp_rsp_dspam = '0;
        forever begin
            @(negedge clk);
            s = cyc % 8;
            f = (cyc + DP_LAT) % 8;
            dp_rsp_valid = pv[s];
            dp_rsp_sum   = SUM_W'(ps[s]);
            dp_rsp_dham  = CNT_W'(ph[s]);
            dp_rsp_dspam = CNT_W'(pp[s]);
            pv[s] = 1'b0;
            pv[f] = 1'b0;
            if (reset) begin
                case (dp_op)
                    OP_ACC: begin
                        a.sym = int'(dp_sym); a.chunk = int'(dp_chunk); a.clr = dp_acc_clr;
                        acc_log.push_back(a);
                    end
                    OP_SUM: begin
                        n_sum++; pv[f] = 1'b1; ps[f] = sum_tab[dp_chunk];
                    end
                    OP_CMP: begin
                        n_cmp++; pv[f] = 1'b1; ph[f] = dham_tab[dp_chunk]; pp[f] = dspam_tab[dp_chunk];
                        if (thr_sum !== exp_thr_run) thr_bad++;
                    end
                    default: ;
                endcase
                if (result_valid) begin
                    n_rv++; rv_cyc = cyc; rv_res = result;
                end
            end
        end
    end

    function automatic int ref_sym(input logic [7:0] ch);
        string      alpha;
        logic [7:0] lc;
        alpha = "0123456789abcdefghijklmnopqrstuvwxyz";
        lc = (ch >= 8'h41 && ch <= 8'h5a) ? ch + 8'd32 : ch;
        for (int i = 0; i < alpha.len(); i++) if (alpha[i] == lc) return i + 1;
        return 0;
    endfunction

    task automatic drive_msg(input int gap_max, output int c_last, output logic busy_first, output int ready_bad);
        ready_bad = 0; busy_first = 1'bx; c_last = -1;
        for (int i = 0; i < msg.size(); i++) begin
            if (gap_max > 0) begin
                repeat (int'($urandom_range(gap_max, 0))) begin
                    char_valid = 1'b0; char_data = 8'($urandom); char_last = 1'($urandom_range(1, 0));
                    @(posedge clk); #1;
                end
            end
            char_valid = 1'b1; char_data = msg[i]; char_last = (i == msg.size() - 1);
            if (char_ready !== 1'b1) ready_bad++;
            if (i == msg.size() - 1) c_last = cyc;
            @(posedge clk); #1;
            if (i == 0) busy_first = busy;
        end
        char_valid = 1'b0; char_last = 1'b0;
    endtask

    task automatic run_msg(input string tag, input int gap_max);
        int tok[$];
        int len, thr, hsum, ssum, c_last, ready_bad, deadline, seq_bad, idx;
        logic busy_first;
        logic [1:0] exp_res;
        foreach (msg[i]) if (tok.size() < MAX_LENGTH) tok.push_back(ref_sym(msg[i]));
        len = tok.size();
        thr = 0; hsum = 0; ssum = 0;
        for (int c = 0; c < NCHK; c++) begin
            thr += sum_tab[c]; hsum += dham_tab[c]; ssum += dspam_tab[c];
        end
        exp_res = (hsum > ssum) ? RES_SPAM : (hsum < ssum) ? RES_HAM : RES_UNDEC;
        exp_thr_run = SUM_W'(thr);
        acc_log.delete(); n_sum = 0; n_cmp = 0; n_rv = 0; thr_bad = 0; rv_cyc = -1; rv_res = 'x;

        drive_msg(gap_max, c_last, busy_first, ready_bad);
        deadline = cyc + NCHK * (len + 2) + 2 * DP_LAT + 50;
        while (n_rv == 0 && cyc < deadline) @(posedge clk);
        #1;

        chk({tag, "/ready"}, ready_bad, 0);
        chk({tag, "/busy_first"}, busy_first, 1);
        chk({tag, "/result_seen"}, n_rv, 1);
        chk({tag, "/result"}, rv_res, exp_res);
        chk({tag, "/latency"}, rv_cyc - c_last, NCHK * (len + 2) + 2 * DP_LAT + 3);
        chk({tag, "/acc_count"}, acc_log.size(), NCHK * len);
        seq_bad = 0;
        if (acc_log.size() == NCHK * len) begin
            idx = 0;
            for (int c = 0; c < NCHK; c++) begin
                for (int t = 0; t < len; t++) begin
                    if (acc_log[idx].sym != tok[t] || acc_log[idx].chunk != c || acc_log[idx].clr != (t == 0))
                        seq_bad++;
                    idx++;
                end
            end
        end
        chk({tag, "/acc_seq"}, seq_bad, 0);
        chk({tag, "/sum_count"}, n_sum, NCHK);
        chk({tag, "/cmp_count"}, n_cmp, NCHK);
        chk({tag, "/thr_in_cmp"}, thr_bad, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "/thr_held"}, thr_sum, thr);
        chk({tag, "/result_held"}, result, exp_res);
        chk({tag, "/busy_after"}, busy, 0);
        chk({tag, "/single_pulse"}, n_rv, 1);
    endtask

    task automatic rand_tables();
        for (int c = 0; c < NCHK; c++) begin
            sum_tab[c]   = int'($urandom_range(100, 0)) - 50;
            dham_tab[c]  = int'($urandom_range(CHUNK, 0));
            dspam_tab[c] = int'($urandom_range(CHUNK, 0));
        end
    endtask

    task automatic rand_msg(input int n);
        msg.delete();
        repeat (n) msg.push_back(8'($urandom_range(126, 32)));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        int c_last, ready_bad, deadline;
        logic busy_first;
        reset = 1'b0; char_valid = 1'b0; char_data = '0; char_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/char_ready", char_ready, 1);
        chk("reset/dp_op", dp_op, OP_NOP);
        chk("reset/busy", busy, 0);
        chk("reset/result_valid", result_valid, 0);
        chk("reset/result", result, RES_SPAM);
        chk("reset/thr_sum", thr_sum, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        msg = {8'h48, 8'h69, 8'h21};
        sum_tab = '{5, -3, 0, -2}; dham_tab = '{1, 2, 0, 3}; dspam_tab = '{4, 4, 4, 4};
        run_msg("hi", 0);

        rand_msg(6);
        dham_tab = '{3, 2, 4, 1}; dspam_tab = '{1, 4, 2, 3};
        run_msg("equal", 2);
        rand_msg(9);
        dham_tab = '{1, 1, 2, 1}; dspam_tab = '{2, 3, 1, 3};
        run_msg("ham", 2);

        msg.delete();
        repeat (205) msg.push_back(8'h61);
        rand_tables();
        run_msg("long", 0);

        msg = {8'h37};
        rand_tables();
        run_msg("single", 0);

        for (int k = 0; k < 4; k++) begin
            rand_msg(int'($urandom_range(40, 1)));
            rand_tables();
            run_msg($sformatf("rand%0d", k), 3);
        end

        rand_msg(10);
        for (int c = 0; c < NCHK; c++) sum_tab[c] = 7 + c;
        dham_tab = '{9, 9, 9, 9}; dspam_tab = '{0, 0, 0, 0};
        exp_thr_run = SUM_W'(7 + 8 + 9 + 10);
        n_rv = 0;
        drive_msg(0, c_last, busy_first, ready_bad);
        deadline = cyc + 500;
        while (dp_op !== OP_CMP && cyc < deadline) @(negedge clk);
        chk("abort/reach_cmp", dp_op, OP_CMP);
        #2 reset = 1'b0;
        #1;
        chk("abort/char_ready", char_ready, 1);
        chk("abort/dp_op", dp_op, OP_NOP);
        chk("abort/dp_acc_clr", dp_acc_clr, 0);
        chk("abort/thr_sum", thr_sum, 0);
        chk("abort/busy", busy, 0);
        chk("abort/result_valid", result_valid, 0);
        chk("abort/result", result, RES_SPAM);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort/no_result", n_rv, 0);
        chk("abort/busy_idle", busy, 0);

        rand_msg(12);
        rand_tables();
        run_msg("after_abort", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
